// File: rtl/icache_pkg.sv
// Shared icache constants and the refill FSM state type.
// The icache controller's set/offset slicing uses the same line geometry.
package icache_pkg;

  localparam int LINE_WORDS       = 32;
  localparam int LINE_BYTES       = LINE_WORDS * 4;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_ISSUE = 2'd1,
    RF_DRAIN = 2'd2
  } refill_state_t;

endpackage

// File: rtl/icache_refill_unit.sv
// Line-refill engine: splits one line request into LINE_WORDS single-word reads
// with a bounded number in flight, and streams the returned words back in order.
//
// Handshakes: a transfer happens on a cycle where valid && ready at posedge clk;
// a raised mem_req_valid keeps valid and addr stable until it is accepted, and the
// memory response port has no backpressure (mem_rsp_valid is always consumed).
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_req_valid,
  output logic                  line_req_ready,
  input  logic [ADDR_WIDTH-1:0] line_req_addr,
  output logic                  line_d_valid,
  output logic [WIDTH-1:0]      line_d_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WIDTH-1:0]      mem_rsp_data,
  output logic                  busy,
  output logic                  err_stray
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  refill_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  req_fire;
  logic                  rsp_take;
  logic                  rsp_stray;

  // A response is only meaningful while something is in flight.
  assign rsp_take  = mem_rsp_valid && (out_q != '0);
  assign rsp_stray = mem_rsp_valid && (out_q == '0);
  assign busy      = (state_q != RF_IDLE);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    issue_idx_d    = issue_idx_q;
    ret_cnt_d      = ret_cnt_q;
    line_req_ready = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    req_fire       = 1'b0;

    if (rsp_take) ret_cnt_d = ret_cnt_q + 1'b1;

    case (state_q)
      RF_IDLE: begin
        line_req_ready = rst;
        if (line_req_valid && rst) begin
          base_d      = line_req_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
          issue_idx_d = '0;
          ret_cnt_d   = '0;
          state_d     = RF_ISSUE;
        end
      end
      RF_ISSUE: begin
        // outstanding cannot rise without a fire, so a raised valid never retracts
        mem_req_valid = (out_q < OUT_W'(MAX_OUTSTANDING));
        mem_req_addr  = base_q + (ADDR_WIDTH'(issue_idx_q) << 2);
        req_fire      = mem_req_valid && mem_req_ready;
        if (req_fire) begin
          issue_idx_d = issue_idx_q + 1'b1;
          if (issue_idx_q == CNT_W'(LINE_WORDS - 1)) state_d = RF_DRAIN;
        end
      end
      RF_DRAIN: begin
        if (rsp_take && (ret_cnt_q == CNT_W'(LINE_WORDS - 1))) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase

    out_d = out_q + OUT_W'(req_fire) - OUT_W'(rsp_take);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RF_IDLE;
      base_q       <= '0;
      issue_idx_q  <= '0;
      ret_cnt_q    <= '0;
      out_q        <= '0;
      line_d_valid <= 1'b0;
      line_d_data  <= '0;
      err_stray    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_idx_q  <= issue_idx_d;
      ret_cnt_q    <= ret_cnt_d;
      out_q        <= out_d;
      line_d_valid <= rsp_take;
      if (rsp_take) line_d_data <= mem_rsp_data;
      err_stray    <= rsp_stray;
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: per-cycle reference model of the line refill
// (address sequence, in-flight bound, in-order beats) driven by a latency memory.
module tb_icache_refill_unit;
  import icache_pkg::*;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_req_valid;
  logic        line_req_ready;
  logic [31:0] line_req_addr;
  logic        line_d_valid;
  logic [31:0] line_d_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
  logic        err_stray;

  always #5 clk = ~clk;

  icache_refill_unit #(.WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_req_valid(line_req_valid),
    .line_req_ready(line_req_ready),
    .line_req_addr (line_req_addr),
    .line_d_valid  (line_d_valid),
    .line_d_data   (line_d_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy),
    .err_stray     (err_stray)
  );

  // Scoreboard and reference-model state
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          m_busy;
  logic [31:0] m_base;
  int          m_fires, m_rsps;
  bit          exp_dvalid, exp_stray;
  bit          want_req, force_stray;
  logic [31:0] req_addr;
  int          lat_min, lat_max, rmode;
  int          beats, max_out;
  logic [31:0] first_addr;
  bit          first_seen;

  typedef struct {
    logic [31:0] addr;
    int          lmin;
    int          lmax;
    int          rmode;
    logic [31:0] exp_base;
    int          exp_beats;
    int          exp_max_out;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive memory/request inputs, advance the model, then check outputs.
  task automatic step();
    int out_before;
    bit fire, take, accept, exp_mv;
    out_before = due_q.size();
    case (rmode)
      0:       mem_req_ready = 1'b1;
      1:       mem_req_ready = ((cyc % 2) == 1);
      default: mem_req_ready = 1'($urandom_range(0, 1));
    endcase
    fire = mem_req_valid && mem_req_ready;
    if (fire) begin
      if (!first_seen) begin
        first_addr = mem_req_addr;
        first_seen = 1'b1;
      end
      m_fires++;
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    take          = 1'b0;
    if (out_before > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom();
      take          = 1'b1;
    end else if (force_stray && out_before == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom();
    end
    if (fire) due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
    if (out_before > max_out) max_out = out_before;
    exp_dvalid = take;
    exp_stray  = mem_rsp_valid && !take;
    if (take) begin
      exp_q.push_back(mem_rsp_data);
      m_rsps++;
    end
    // Requests while busy are noise the unit must ignore.
    line_req_valid = want_req || (m_busy && $urandom_range(0, 3) == 0);
    line_req_addr  = want_req ? req_addr : $urandom();
    accept = want_req && !m_busy;
    if (take && m_rsps == LINE_WORDS) m_busy = 1'b0;
    if (accept) begin
      m_busy     = 1'b1;
      m_base     = req_addr & ~32'(LINE_BYTES - 1);
      m_fires    = 0;
      m_rsps     = 0;
      want_req   = 1'b0;
      beats      = 0;
      max_out    = 0;
      first_seen = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("d_valid", 32'(line_d_valid), 32'(exp_dvalid));
    if (exp_dvalid) begin
      check("d_data", line_d_data, exp_q.pop_front());
      beats++;
    end
    check("err_stray", 32'(err_stray), 32'(exp_stray));
    check("busy", 32'(busy), 32'(m_busy));
    check("line_req_ready", 32'(line_req_ready), 32'(!m_busy));
    exp_mv = m_busy && (m_fires < LINE_WORDS) && (due_q.size() < MAXO);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mv));
    if (exp_mv) check("mem_req_addr", mem_req_addr, m_base + 32'(4 * m_fires));
  endtask

  task automatic run_line(input logic [31:0] addr, input int lmin, input int lmax, input int rm);
    int guard;
    guard    = 0;
    want_req = 1'b1;
    req_addr = addr;
    lat_min  = lmin;
    lat_max  = lmax;
    rmode    = rm;
    while ((want_req || m_busy || exp_q.size() > 0) && guard < 3000) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 3000) begin
      n_err++;
      $display("FAIL run_timeout: got %0d cycles expected completion for addr 0x%08h", guard, addr);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          g;
    vecs[0] = '{32'h0000_1234, 1, 1, 0, 32'h0000_1200, 32, 1};
    vecs[1] = '{32'h0000_ABFF, 10, 10, 0, 32'h0000_AB80, 32, 4};
    vecs[2] = '{32'h8000_0005, 1, 3, 1, 32'h8000_0000, 32, -1};
    vecs[3] = '{32'hFFFF_FFFF, 3, 3, 0, 32'hFFFF_FF80, 32, 3};
    vecs[4] = '{32'h0000_0F80, 1, 12, 2, 32'h0000_0F80, 32, -1};

    // Clock/reset block; request held high to show ready stays low in reset
    rst = 1'b0; line_req_valid = 1'b1; line_req_addr = 32'h1234;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    m_busy = 1'b0; want_req = 1'b0; force_stray = 1'b0;
    lat_min = 1; lat_max = 1; rmode = 0; beats = 0; max_out = 0; first_seen = 1'b0;
    m_base = '0; m_fires = 0; m_rsps = 0; first_addr = '0; req_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(line_req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_d_valid", 32'(line_d_valid), 0);
    check("rst_d_data", line_d_data, 0);
    check("rst_mem_valid", 32'(mem_req_valid), 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_err", 32'(err_stray), 0);
    rst = 1'b1;
    line_req_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(line_req_ready), 1);

    // Table-driven line refills
    for (int i = 0; i < 5; i++) begin
      run_line(vecs[i].addr, vecs[i].lmin, vecs[i].lmax, vecs[i].rmode);
      check($sformatf("v%0d_first_addr", i), first_addr, vecs[i].exp_base);
      check($sformatf("v%0d_beats", i), 32'(beats), 32'(vecs[i].exp_beats));
      if (vecs[i].exp_max_out >= 0)
        check($sformatf("v%0d_max_out", i), 32'(max_out), 32'(vecs[i].exp_max_out));
      idle_steps(2);
    end

    // Back-to-back: new request offered the cycle the last beat appears
    run_line(32'h0000_4444, 2, 2, 0);
    run_line(32'h0000_5000, 1, 1, 0);
    check("b2b_first_addr", first_addr, 32'h0000_5000);
    check("b2b_beats", 32'(beats), 32);

    // Randomized lines
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      run_line(a, 1, $urandom_range(1, 12), 2);
      check("rand_first_addr", first_addr, a & ~32'(LINE_BYTES - 1));
      check("rand_beats", 32'(beats), 32);
      check("rand_out_bound", 32'(max_out <= MAXO), 1);
      idle_steps($urandom_range(0, 3));
    end

    // Stray response in IDLE: dropped, one-cycle err_stray
    force_stray = 1'b1;
    step();
    force_stray = 1'b0;
    idle_steps(3);

    // Reset after 10 beats abandons the line
    want_req = 1'b1; req_addr = 32'h0000_3000; lat_min = 2; lat_max = 5; rmode = 2;
    g = 0;
    while (!(m_busy && beats >= 10) && g < 1000) begin
      step();
      g++;
    end
    check("pre_reset_beats", 32'(beats), 10);
    rst = 1'b0; line_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cyc++;
    m_busy = 1'b0; due_q.delete(); exp_q.delete();
    check("mid_rst_d_valid", 32'(line_d_valid), 0);
    check("mid_rst_d_data", line_d_data, 0);
    check("mid_rst_mem_valid", 32'(mem_req_valid), 0);
    check("mid_rst_mem_addr", mem_req_addr, 0);
    check("mid_rst_err", 32'(err_stray), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(line_req_ready), 1);
    run_line(32'h0000_2000, 1, 4, 2);
    check("after_rst_first_addr", first_addr, 32'h0000_2000);
    check("after_rst_beats", 32'(beats), 32);
    idle_steps(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
